// File: rtl/vid_pkg.sv
// Shared definitions for the video page engine: command opcodes, FSM state
// encodings and the linear pixel address helper.
package vid_pkg;

    typedef enum logic [1:0] {
        OP_FILL = 2'd0,
        OP_COPY = 2'd1,
        OP_BLIT = 2'd2,
        OP_RSVD = 2'd3
    } vid_op_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FILL     = 3'd1,
        ST_COPY     = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_WAIT_VBL = 3'd4,
        ST_FINISH   = 3'd5
    } vid_state_e;

    // Linear frame-buffer address: page*WIDTH*HEIGHT + y*WIDTH + x.
    function automatic int unsigned pix_addr(input int unsigned page,
                                             input int unsigned y,
                                             input int unsigned x,
                                             input int unsigned width,
                                             input int unsigned height);
        return page * width * height + y * width + x;
    endfunction

endpackage

// File: rtl/vid_page_engine_if.sv
// Command, pixel-memory and status bundle of the video page engine.
//
// Command handshake: a command is taken on a rising clock edge where
// cmd_valid and cmd_ready are both 1. The engine raises cmd_ready only while
// idle; all cmd_* fields are captured on that edge and ignored afterwards.
// The requester may hold cmd_valid high without a transfer while cmd_ready
// is low. pix_rd_data must carry the word addressed by pix_rd_addr exactly
// one cycle after pix_rd_en.
interface vid_page_engine_if #(
    parameter int COLOR_BITS = 4,
    parameter int ADDR_W     = 18
);
    import vid_pkg::*;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [7:0]            cmd_src;
    logic [7:0]            cmd_dst;
    logic [COLOR_BITS-1:0] cmd_color;
    logic [15:0]           cmd_vscroll;
    logic                  vblank;
    logic                  pix_rd_en;
    logic [ADDR_W-1:0]     pix_rd_addr;
    logic [COLOR_BITS-1:0] pix_rd_data;
    logic                  pix_wr_en;
    logic [ADDR_W-1:0]     pix_wr_addr;
    logic [COLOR_BITS-1:0] pix_wr_data;
    logic [7:0]            front_page;
    logic                  busy;
    logic                  done;
    logic                  err;
    vid_state_e            dbg_state;

    modport slave (
        input  cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_color, cmd_vscroll,
        input  vblank, pix_rd_data,
        output cmd_ready, pix_rd_en, pix_rd_addr, pix_wr_en, pix_wr_addr,
        output pix_wr_data, front_page, busy, done, err, dbg_state
    );

    modport master (
        output cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_color, cmd_vscroll,
        output vblank, pix_rd_data,
        input  cmd_ready, pix_rd_en, pix_rd_addr, pix_wr_en, pix_wr_addr,
        input  pix_wr_data, front_page, busy, done, err, dbg_state
    );

endinterface

// File: rtl/vid_raster_cnt.sv
// Raster x/y walker: x runs 0..WIDTH-1 on every step, y moves up or down one
// row on x wrap. last_o flags the final pixel (x at end of row, y on the
// row captured as last at load time).
module vid_raster_cnt #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 200,
    parameter int XW     = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
    parameter int YW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_i,
    input  logic          step_i,
    input  logic          down_i,
    input  logic [YW-1:0] y_start_i,
    input  logic [YW-1:0] y_last_i,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          last_o
);
    localparam logic [XW-1:0] X_MAX = XW'(WIDTH - 1);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [YW-1:0] y_last_q, y_last_d;
    logic          down_q, down_d;

    // Next position: load wins over step; x wraps and y moves by direction.
    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        y_last_d = y_last_q;
        down_d   = down_q;
        if (load_i) begin
            x_d      = '0;
            y_d      = y_start_i;
            y_last_d = y_last_i;
            down_d   = down_i;
        end else if (step_i) begin
            if (x_q == X_MAX) begin
                x_d = '0;
                y_d = down_q ? (y_q - YW'(1)) : (y_q + YW'(1));
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    // Position and walk configuration registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q      <= '0;
            y_q      <= '0;
            y_last_q <= '0;
            down_q   <= 1'b0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            y_last_q <= y_last_d;
            down_q   <= down_d;
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign last_o = (x_q == X_MAX) && (y_q == y_last_q);

endmodule

// File: rtl/vid_page_engine.sv
// Video page engine: FILL a page with a colour, COPY a page with a signed
// vertical scroll (pipelined read->write, one pixel per clock), and BLIT a
// page to the display on vertical blank. Bad commands finish with err.
module vid_page_engine
    import vid_pkg::*;
#(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 200,
    parameter int NUM_PAGES  = 4,
    parameter int COLOR_BITS = 4
) (
    input logic          clk,
    input logic          reset,
    vid_page_engine_if.slave bus
);
    localparam int ADDR_W = $clog2(NUM_PAGES * WIDTH * HEIGHT);
    localparam int XW     = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [YW-1:0] Y_MAX    = YW'(HEIGHT - 1);
    localparam logic [7:0]    PAGE_LIM = 8'(NUM_PAGES);
    localparam logic [16:0]   H_LIM    = 17'(HEIGHT);

    vid_state_e            state_q, state_d;
    logic [7:0]            src_q, dst_q;
    logic [COLOR_BITS-1:0] color_q;
    logic [YW-1:0]         vs_q;
    logic                  err_q, err_d;
    logic [7:0]            front_page_q, front_page_d;
    logic                  wr_pend_q;
    logic [ADDR_W-1:0]     wr_addr_q;
    logic                  latch;

    logic                  cnt_load, cnt_step, cnt_down, cnt_last;
    logic [YW-1:0]         cnt_y_start, cnt_y_last, cnt_y, src_y;
    logic [XW-1:0]         cnt_x;

    logic                  rd_en, wr_en;
    logic [ADDR_W-1:0]     rd_addr, wr_addr, dst_addr;
    logic [COLOR_BITS-1:0] wr_data;

    logic                  src_bad, dst_bad, copy_noop;
    logic signed [16:0]    vs_ext;
    logic [16:0]           vs_abs;

    vid_raster_cnt #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .XW(XW), .YW(YW)) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .load_i    (cnt_load),
        .step_i    (cnt_step),
        .down_i    (cnt_down),
        .y_start_i (cnt_y_start),
        .y_last_i  (cnt_y_last),
        .x_o       (cnt_x),
        .y_o       (cnt_y),
        .last_o    (cnt_last)
    );

    // Incoming command qualification; |vscroll| is 17 bits so -32768 is exact.
    assign vs_ext    = {bus.cmd_vscroll[15], bus.cmd_vscroll};
    assign vs_abs    = vs_ext[16] ? 17'(-vs_ext) : 17'(vs_ext);
    assign src_bad   = bus.cmd_src >= PAGE_LIM;
    assign dst_bad   = bus.cmd_dst >= PAGE_LIM;
    assign copy_noop = (vs_abs >= H_LIM) ||
                       ((bus.cmd_src == bus.cmd_dst) && (bus.cmd_vscroll == 16'd0));

    // Source row wraps modulo 2^YW; the walked rows keep it inside the page.
    assign src_y    = cnt_y + vs_q;
    assign dst_addr = ADDR_W'(pix_addr(32'(dst_q), 32'(cnt_y), 32'(cnt_x), WIDTH, HEIGHT));

    // Next-state and pixel-port decode.
    always_comb begin
        state_d      = state_q;
        err_d        = err_q;
        front_page_d = front_page_q;
        latch        = 1'b0;
        cnt_load     = 1'b0;
        cnt_step     = 1'b0;
        cnt_down     = 1'b0;
        cnt_y_start  = '0;
        cnt_y_last   = Y_MAX;
        rd_en        = 1'b0;
        rd_addr      = '0;
        wr_en        = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    latch = 1'b1;
                    err_d = 1'b0;
                    case (bus.cmd_op)
                        OP_FILL: begin
                            if (src_bad) begin
                                err_d   = 1'b1;
                                state_d = ST_FINISH;
                            end else begin
                                cnt_load = 1'b1;
                                state_d  = ST_FILL;
                            end
                        end
                        OP_COPY: begin
                            if (src_bad || dst_bad) begin
                                err_d   = 1'b1;
                                state_d = ST_FINISH;
                            end else if (copy_noop) begin
                                state_d = ST_FINISH;
                            end else begin
                                // Scrolling up walks top-down, down walks bottom-up,
                                // so an in-place copy never reads a row it rewrote.
                                cnt_load    = 1'b1;
                                cnt_down    = vs_ext[16];
                                cnt_y_start = vs_ext[16] ? Y_MAX : '0;
                                cnt_y_last  = vs_ext[16] ? vs_abs[YW-1:0]
                                                         : (Y_MAX - vs_abs[YW-1:0]);
                                state_d     = ST_COPY;
                            end
                        end
                        OP_BLIT: begin
                            if (src_bad) begin
                                err_d   = 1'b1;
                                state_d = ST_FINISH;
                            end else if (bus.vblank) begin
                                front_page_d = bus.cmd_src;
                                state_d      = ST_FINISH;
                            end else begin
                                state_d = ST_WAIT_VBL;
                            end
                        end
                        default: begin
                            err_d   = 1'b1;
                            state_d = ST_FINISH;
                        end
                    endcase
                end
            end
            ST_FILL: begin
                wr_en    = 1'b1;
                wr_addr  = ADDR_W'(pix_addr(32'(src_q), 32'(cnt_y), 32'(cnt_x), WIDTH, HEIGHT));
                wr_data  = color_q;
                cnt_step = 1'b1;
                if (cnt_last) state_d = ST_FINISH;
            end
            ST_COPY: begin
                rd_en    = 1'b1;
                rd_addr  = ADDR_W'(pix_addr(32'(src_q), 32'(src_y), 32'(cnt_x), WIDTH, HEIGHT));
                wr_en    = wr_pend_q;
                wr_addr  = wr_pend_q ? wr_addr_q : '0;
                wr_data  = wr_pend_q ? bus.pix_rd_data : '0;
                cnt_step = 1'b1;
                if (cnt_last) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                wr_en   = wr_pend_q;
                wr_addr = wr_pend_q ? wr_addr_q : '0;
                wr_data = wr_pend_q ? bus.pix_rd_data : '0;
                state_d = ST_FINISH;
            end
            ST_WAIT_VBL: begin
                if (bus.vblank) begin
                    front_page_d = src_q;
                    state_d      = ST_FINISH;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State, latched command fields and the one-deep copy write pipeline.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            color_q      <= '0;
            vs_q         <= '0;
            err_q        <= 1'b0;
            front_page_q <= '0;
            wr_pend_q    <= 1'b0;
            wr_addr_q    <= '0;
        end else begin
            state_q      <= state_d;
            err_q        <= err_d;
            front_page_q <= front_page_d;
            wr_pend_q    <= (state_q == ST_COPY);
            wr_addr_q    <= dst_addr;
            if (latch) begin
                src_q   <= bus.cmd_src;
                dst_q   <= bus.cmd_dst;
                color_q <= bus.cmd_color;
                vs_q    <= bus.cmd_vscroll[YW-1:0];
            end
        end
    end

    assign bus.cmd_ready   = (state_q == ST_IDLE);
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.done        = (state_q == ST_FINISH);
    assign bus.err         = (state_q == ST_FINISH) && err_q;
    assign bus.front_page  = front_page_q;
    assign bus.dbg_state   = state_q;
    assign bus.pix_rd_en   = rd_en;
    assign bus.pix_rd_addr = rd_addr;
    assign bus.pix_wr_en   = wr_en;
    assign bus.pix_wr_addr = wr_addr;
    assign bus.pix_wr_data = wr_data;

endmodule

// File: tb/tb_vid_page_engine.sv
// Directed bench for vid_page_engine on an 8x4, 4-page frame buffer.
module tb_vid_page_engine;
    import vid_pkg::*;

    localparam int WIDTH      = 8;
    localparam int HEIGHT     = 4;
    localparam int NUM_PAGES  = 4;
    localparam int COLOR_BITS = 4;
    localparam int ADDR_W     = $clog2(NUM_PAGES * WIDTH * HEIGHT);
    localparam int MEM_N      = NUM_PAGES * WIDTH * HEIGHT;
    localparam int PAGE_SZ    = WIDTH * HEIGHT;
    localparam int W          = ADDR_W + COLOR_BITS;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    vid_page_engine_if #(.COLOR_BITS(COLOR_BITS), .ADDR_W(ADDR_W)) bus ();

    vid_page_engine #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .NUM_PAGES(NUM_PAGES), .COLOR_BITS(COLOR_BITS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- pixel memory ----------------
    logic [COLOR_BITS-1:0] mem     [MEM_N];
    logic [COLOR_BITS-1:0] ref_mem [MEM_N];
    logic                  mem_init;

    function automatic logic [COLOR_BITS-1:0] pat(input int a);
        return COLOR_BITS'(a * 7 + 3);
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int a = 0; a < MEM_N; a++) mem[a] <= pat(a);
        end else begin
            if (bus.pix_wr_en) mem[bus.pix_wr_addr] <= bus.pix_wr_data;
        end
        if (bus.pix_rd_en) bus.pix_rd_data <= mem[bus.pix_rd_addr];
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];
    int wr_cnt = 0;
    int rd_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.pix_rd_en) rd_cnt++;
        if (bus.pix_wr_en) begin
            wr_cnt++;
            if (exp_q.size() == 0)
                chk("wr_unexpected", 32'({bus.pix_wr_addr, bus.pix_wr_data}), 32'hFFFF_FFFF);
            else
                chk("wr_addr_data", 32'({bus.pix_wr_addr, bus.pix_wr_data}), 32'(exp_q.pop_front()));
        end
        if ((bus.pix_wr_en || bus.pix_rd_en) &&
            !(bus.dbg_state inside {ST_FILL, ST_COPY, ST_DRAIN}))
            chk("strobe_state", 32'(bus.dbg_state), 32'(ST_COPY));
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [1:0] op, input logic [7:0] src, input logic [7:0] dst,
                        input logic [COLOR_BITS-1:0] color, input logic [15:0] vs);
        @(negedge clk);
        chk("cmd_ready", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid   = 1'b1;
        bus.cmd_op      = op;
        bus.cmd_src     = src;
        bus.cmd_dst     = dst;
        bus.cmd_color   = color;
        bus.cmd_vscroll = vs;
        @(negedge clk);
        bus.cmd_valid   = 1'b0;
        bus.cmd_op      = 2'($urandom_range(0, 3));
        bus.cmd_src     = 8'($urandom_range(0, 255));
        bus.cmd_dst     = 8'($urandom_range(0, 255));
        bus.cmd_color   = COLOR_BITS'($urandom_range(0, 15));
        bus.cmd_vscroll = 16'($urandom_range(0, 65535));
    endtask

    // Cycle index 1 is the first cycle after acceptance; 0 means timeout.
    task automatic wait_done(input int max, output int cyc, output logic e);
        cyc = 0;
        e   = 1'b0;
        for (int i = 1; i <= max; i++) begin
            if (bus.done) begin
                cyc = i;
                e   = bus.err;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic finish_cmd(input string tag, input int exp_cyc, input logic exp_err,
                              input int w0, input int exp_wr, input int r0, input int exp_rd);
        int   cyc;
        logic e;
        wait_done(60, cyc, e);
        chk({tag, "_done_cycle"}, 32'(cyc), 32'(exp_cyc));
        chk({tag, "_err"}, 32'(e), 32'(exp_err));
        chk({tag, "_writes"}, 32'(wr_cnt - w0), 32'(exp_wr));
        chk({tag, "_reads"}, 32'(rd_cnt - r0), 32'(exp_rd));
        chk({tag, "_exp_q_left"}, 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    endtask

    task automatic chk_mem(input string tag);
        int bad = 0;
        for (int a = 0; a < MEM_N; a++) if (mem[a] !== ref_mem[a]) bad++;
        chk(tag, 32'(bad), 32'd0);
    endtask

    // Expected writes and memory image of COPY dst(x,y) = src(x,y+vs).
    task automatic copy_expect(input int src, input int dst, input int vs);
        logic [COLOR_BITS-1:0] snap [MEM_N];
        int addr;
        for (int a = 0; a < MEM_N; a++) snap[a] = ref_mem[a];
        for (int k = 0; k < HEIGHT; k++) begin
            int y;
            y = (vs < 0) ? (HEIGHT - 1 - k) : k;
            if (y + vs >= 0 && y + vs < HEIGHT) begin
                for (int x = 0; x < WIDTH; x++) begin
                    addr = dst * PAGE_SZ + y * WIDTH + x;
                    ref_mem[addr] = snap[src * PAGE_SZ + (y + vs) * WIDTH + x];
                    exp_q.push_back({ADDR_W'(addr), ref_mem[addr]});
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int w0, r0, bad;

        bus.cmd_valid   = 1'b0;
        bus.cmd_op      = '0;
        bus.cmd_src     = '0;
        bus.cmd_dst     = '0;
        bus.cmd_color   = '0;
        bus.cmd_vscroll = '0;
        bus.vblank      = 1'b0;
        mem_init        = 1'b1;
        for (int a = 0; a < MEM_N; a++) ref_mem[a] = pat(a);

        // Reset values, before any clock edge.
        #1;
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_rd_en", 32'(bus.pix_rd_en), 32'd0);
        chk("rst_wr_en", 32'(bus.pix_wr_en), 32'd0);
        chk("rst_rd_addr", 32'(bus.pix_rd_addr), 32'd0);
        chk("rst_wr_addr", 32'(bus.pix_wr_addr), 32'd0);
        chk("rst_wr_data", 32'(bus.pix_wr_data), 32'd0);
        chk("rst_front_page", 32'(bus.front_page), 32'd0);
        chk("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
        repeat (2) @(negedge clk);
        mem_init = 1'b0;
        reset    = 1'b1;

        // FILL page 2 colour A: addresses 64..95, done at cycle 33.
        for (int i = 0; i < PAGE_SZ; i++) begin
            ref_mem[64 + i] = 4'hA;
            exp_q.push_back({ADDR_W'(64 + i), 4'hA});
        end
        w0 = wr_cnt; r0 = rd_cnt;
        send(2'd0, 8'd2, 8'd0, 4'hA, 16'd0);
        finish_cmd("fill_p2", 33, 1'b0, w0, 32, r0, 0);
        chk_mem("fill_p2_mem");

        // COPY 0 -> 1, vscroll +1: 24 reads, drain, done at cycle 26.
        copy_expect(0, 1, 1);
        w0 = wr_cnt; r0 = rd_cnt;
        send(2'd1, 8'd0, 8'd1, 4'h0, 16'd1);
        finish_cmd("copy_up", 26, 1'b0, w0, 24, r0, 24);
        chk_mem("copy_up_mem");

        // COPY 1 -> 1 in place, vscroll -1, bottom-up.
        copy_expect(1, 1, -1);
        w0 = wr_cnt; r0 = rd_cnt;
        send(2'd1, 8'd1, 8'd1, 4'h0, 16'hFFFF);
        finish_cmd("copy_dn", 26, 1'b0, w0, 24, r0, 24);
        chk_mem("copy_dn_mem");

        // COPY with vscroll -3 leaves one row.
        copy_expect(2, 3, -3);
        w0 = wr_cnt; r0 = rd_cnt;
        send(2'd1, 8'd2, 8'd3, 4'h0, 16'hFFFD);
        finish_cmd("copy_m3", 10, 1'b0, w0, 8, r0, 8);
        chk_mem("copy_m3_mem");

        // No-op copies: |vscroll| >= HEIGHT, and src==dst with zero scroll.
        w0 = wr_cnt; r0 = rd_cnt;
        send(2'd1, 8'd2, 8'd3, 4'h0, 16'd4);
        finish_cmd("copy_vs4", 1, 1'b0, w0, 0, r0, 0);
        w0 = wr_cnt; r0 = rd_cnt;
        send(2'd1, 8'd0, 8'd1, 4'h0, 16'hFFFB);
        finish_cmd("copy_vsm5", 1, 1'b0, w0, 0, r0, 0);
        w0 = wr_cnt; r0 = rd_cnt;
        send(2'd1, 8'd2, 8'd2, 4'h0, 16'd0);
        finish_cmd("copy_self0", 1, 1'b0, w0, 0, r0, 0);

        // BLIT page 3 with vblank low for 10 cycles.
        send(2'd2, 8'd3, 8'd0, 4'h0, 16'd0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.front_page != 8'd0 || bus.done) bad++;
            @(negedge clk);
        end
        chk("blit_wait_front", 32'(bad), 32'd0);
        chk("blit_wait_state", 32'(bus.dbg_state), 32'(ST_WAIT_VBL));
        chk("blit_wait_busy", 32'(bus.busy), 32'd1);
        bus.vblank = 1'b1;
        @(negedge clk);
        bus.vblank = 1'b0;
        chk("blit_front", 32'(bus.front_page), 32'd3);
        chk("blit_done", 32'(bus.done), 32'd1);
        chk("blit_err", 32'(bus.err), 32'd0);
        @(negedge clk);
        chk("blit_done_pulse", 32'(bus.done), 32'd0);

        // BLIT page 1 while vblank is already high: no wait.
        bus.vblank = 1'b1;
        w0 = wr_cnt; r0 = rd_cnt;
        send(2'd2, 8'd1, 8'd0, 4'h0, 16'd0);
        bus.vblank = 1'b0;
        chk("blit_now_front", 32'(bus.front_page), 32'd1);
        finish_cmd("blit_now", 1, 1'b0, w0, 0, r0, 0);

        // Rejected commands.
        w0 = wr_cnt; r0 = rd_cnt;
        send(2'd0, 8'd4, 8'd0, 4'h5, 16'd0);
        finish_cmd("fill_p4", 1, 1'b1, w0, 0, r0, 0);
        w0 = wr_cnt; r0 = rd_cnt;
        send(2'd3, 8'd0, 8'd0, 4'h0, 16'd0);
        finish_cmd("op_rsvd", 1, 1'b1, w0, 0, r0, 0);
        w0 = wr_cnt; r0 = rd_cnt;
        send(2'd1, 8'd0, 8'd9, 4'h0, 16'd1);
        finish_cmd("copy_dst9", 1, 1'b1, w0, 0, r0, 0);
        w0 = wr_cnt; r0 = rd_cnt;
        send(2'd2, 8'd7, 8'd0, 4'h0, 16'd0);
        finish_cmd("blit_p7", 1, 1'b1, w0, 0, r0, 0);
        chk("blit_p7_front", 32'(bus.front_page), 32'd1);
        chk_mem("reject_mem");

        // Reset while FILL page 0 presents pixel 10: pixels 0..9 stay written.
        for (int i = 0; i <= 10; i++) begin
            if (i < 10) ref_mem[i] = 4'h5;
            exp_q.push_back({ADDR_W'(i), 4'h5});
        end
        w0 = wr_cnt;
        send(2'd0, 8'd0, 8'd0, 4'h5, 16'd0);
        #2;
        for (int i = 0; i < 20 && (wr_cnt - w0) < 11; i++) begin
            @(negedge clk);
            #2;
        end
        chk("abort_reached_px10", 32'(wr_cnt - w0), 32'd11);
        reset = 1'b0;
        #1;
        chk("abort_wr_en", 32'(bus.pix_wr_en), 32'd0);
        chk("abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("abort_front_page", 32'(bus.front_page), 32'd0);
        chk("abort_state", 32'(bus.dbg_state), 32'(ST_IDLE));
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.done) bad++;
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.done) bad++;
        end
        chk("abort_no_done", 32'(bad), 32'd0);
        chk("abort_writes", 32'(wr_cnt - w0), 32'd11);
        chk("abort_exp_q_left", 32'(exp_q.size()), 32'd0);
        chk_mem("abort_mem");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
